// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver: synchronises rx, validates the start bit at
// its centre, samples each bit mid-period and strobes each good byte for one cycle.
module uart_rx #(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int BAUD_RATE   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       rx_frame_error
);

    localparam int BAUD_PERIOD_CYCLES = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF_PERIOD_CYCLES = BAUD_PERIOD_CYCLES / 2;
    localparam int CNT_W = (BAUD_PERIOD_CYCLES > 1) ? $clog2(BAUD_PERIOD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             rx_s;

    assign rx_s = sync2_q;

    always_comb begin
        sync1_d   = rx;
        sync2_d   = sync1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end

            // A start bit that is no longer low at its centre was a glitch.
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            // Leaving at the stop-bit centre lets a back-to-back start bit be caught.
            STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        rx_data_d = shift_q;
                        valid_d   = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            rx_data_q <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign rx_data        = rx_data_q;
    assign rx_data_valid  = valid_q;
    assign rx_frame_error = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: three instances (default 1250-cycle bit, 125-cycle
// bit with odd period, 8-cycle bit) driven with hand-built 8N1 frames.
module tb_uart_rx;

    localparam int P_A = 1250;
    localparam int H_A = 625;
    localparam int P_B = 8;
    localparam int H_B = 4;
    localparam int P_C = 125;
    localparam int H_C = 62;
    localparam int LAT_A = 2 + H_A + 9 * P_A;
    localparam int LAT_B = 2 + H_B + 9 * P_B;
    localparam int LAT_C = 2 + H_C + 9 * P_C;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_a, rx_b, rx_c;
    logic [7:0] rx_data_a, rx_data_b, rx_data_c;
    logic       valid_a, valid_b, valid_c;
    logic       ferr_a, ferr_b, ferr_c;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    logic [2:0] valid_v;
    logic [2:0] err_v;
    logic [7:0] data_v [3];
    int         valid_cnt [3] = '{0, 0, 0};
    int         err_cnt [3]   = '{0, 0, 0};
    int         err_cyc [3]   = '{0, 0, 0};
    int         valid_cyc [3][16];
    logic [7:0] valid_dat [3][16];
    int         overlap_cnt   = 0;

    uart_rx u_dut_a (
        .clk(clk), .rst(rst), .rx(rx_a),
        .rx_data(rx_data_a), .rx_data_valid(valid_a), .rx_frame_error(ferr_a)
    );

    uart_rx #(.CLK_FREQ_HZ(1000000), .BAUD_RATE(115200)) u_dut_b (
        .clk(clk), .rst(rst), .rx(rx_b),
        .rx_data(rx_data_b), .rx_data_valid(valid_b), .rx_frame_error(ferr_b)
    );

    uart_rx #(.CLK_FREQ_HZ(1200000), .BAUD_RATE(9600)) u_dut_c (
        .clk(clk), .rst(rst), .rx(rx_c),
        .rx_data(rx_data_c), .rx_data_valid(valid_c), .rx_frame_error(ferr_c)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    assign valid_v   = {valid_c, valid_b, valid_a};
    assign err_v     = {ferr_c, ferr_b, ferr_a};
    assign data_v[0] = rx_data_a;
    assign data_v[1] = rx_data_b;
    assign data_v[2] = rx_data_c;

    // Log every strobe with the cycle index of the edge that raised it.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (valid_v[i]) begin
                if (valid_cnt[i] < 16) begin
                    valid_cyc[i][valid_cnt[i]] <= cycle;
                    valid_dat[i][valid_cnt[i]] <= data_v[i];
                end
                valid_cnt[i] <= valid_cnt[i] + 1;
            end
            if (err_v[i]) begin
                err_cyc[i] <= cycle;
                err_cnt[i] <= err_cnt[i] + 1;
            end
        end
        if ((valid_v & err_v) != 3'b000) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic checkOutput(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", tag, got, got, exp, exp);
        end
    endtask

    task automatic driveLine(input int sel, input logic v);
        case (sel)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic sendBit(input int sel, input logic v, input int period);
        driveLine(sel, v);
        repeat (period) @(negedge clk);
    endtask

    // Drives one full frame: start, 8 data bits LSB first, stop of the given level.
    task automatic applyStimulus(input int sel, input logic [7:0] data, input logic stop, input int period);
        sendBit(sel, 1'b0, period);
        for (int b = 0; b < 8; b++) sendBit(sel, data[b], period);
        sendBit(sel, stop, period);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e0;
        int vb;
        int eb;

        rst  = 1'b1;
        rx_a = 1'b1;
        rx_b = 1'b1;
        rx_c = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_data_a", rx_data_a, 8'h00);
        checkOutput("reset_valid_a", valid_a, 0);
        checkOutput("reset_ferr_a", ferr_a, 0);
        checkOutput("reset_data_c", rx_data_c, 8'h00);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Single default-rate frame 0xFB.
        vb = valid_cnt[0];
        eb = err_cnt[0];
        e0 = cycle + 1;
        applyStimulus(0, 8'hFB, 1'b1, P_A);
        repeat (10) @(negedge clk);
        checkOutput("fb_count", valid_cnt[0] - vb, 1);
        checkOutput("fb_data", valid_dat[0][vb], 8'hFB);
        checkOutput("fb_latency", valid_cyc[0][vb] - e0, LAT_A);
        checkOutput("fb_no_ferr", err_cnt[0] - eb, 0);
        checkOutput("fb_hold", rx_data_a, 8'hFB);

        // Back-to-back 0x00 and 0xFF with no idle gap.
        vb = valid_cnt[0];
        e0 = cycle + 1;
        applyStimulus(0, 8'h00, 1'b1, P_A);
        applyStimulus(0, 8'hFF, 1'b1, P_A);
        repeat (10) @(negedge clk);
        checkOutput("b2b_count", valid_cnt[0] - vb, 2);
        checkOutput("b2b_data0", valid_dat[0][vb], 8'h00);
        checkOutput("b2b_data1", valid_dat[0][vb+1], 8'hFF);
        checkOutput("b2b_latency0", valid_cyc[0][vb] - e0, LAT_A);
        checkOutput("b2b_spacing", valid_cyc[0][vb+1] - valid_cyc[0][vb], 10 * P_A);
        checkOutput("b2b_no_ferr", err_cnt[0] - eb, 0);

        // Start glitches of 30 cycles and of exactly H cycles are rejected.
        vb = valid_cnt[2];
        eb = err_cnt[2];
        sendBit(2, 1'b0, 30);
        sendBit(2, 1'b1, 2 * P_C);
        sendBit(2, 1'b0, H_C);
        sendBit(2, 1'b1, 2 * P_C);
        checkOutput("glitch_no_valid", valid_cnt[2] - vb, 0);
        checkOutput("glitch_no_ferr", err_cnt[2] - eb, 0);
        e0 = cycle + 1;
        applyStimulus(2, 8'hA5, 1'b1, P_C);
        repeat (10) @(negedge clk);
        checkOutput("a5_count", valid_cnt[2] - vb, 1);
        checkOutput("a5_data", valid_dat[2][vb], 8'hA5);
        checkOutput("a5_latency", valid_cyc[2][vb] - e0, LAT_C);

        // Bad stop bit followed by a break, then a good frame.
        vb = valid_cnt[2];
        e0 = cycle + 1;
        applyStimulus(2, 8'h3C, 1'b0, P_C);
        sendBit(2, 1'b0, 3 * P_C);
        sendBit(2, 1'b1, 2 * P_C);
        checkOutput("ferr_count", err_cnt[2] - eb, 1);
        checkOutput("ferr_latency", err_cyc[2] - e0, LAT_C);
        checkOutput("ferr_no_valid", valid_cnt[2] - vb, 0);
        checkOutput("ferr_data_kept", rx_data_c, 8'hA5);
        applyStimulus(2, 8'h5A, 1'b1, P_C);
        repeat (10) @(negedge clk);
        checkOutput("5a_count", valid_cnt[2] - vb, 1);
        checkOutput("5a_data", valid_dat[2][vb], 8'h5A);
        checkOutput("5a_ferr_total", err_cnt[2] - eb, 1);

        // Reset pulse in the middle of data bit 4 of an 0xF0 frame.
        vb = valid_cnt[2];
        eb = err_cnt[2];
        sendBit(2, 1'b0, P_C);
        for (int b = 0; b < 4; b++) sendBit(2, 1'b0, P_C);
        sendBit(2, 1'b1, P_C / 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_data", rx_data_c, 8'h00);
        checkOutput("rst_valid", valid_c, 0);
        checkOutput("rst_ferr", ferr_c, 0);
        sendBit(2, 1'b1, P_C - P_C / 2 - 1);
        for (int b = 5; b < 8; b++) sendBit(2, 1'b1, P_C);
        sendBit(2, 1'b1, 3 * P_C);
        checkOutput("rst_no_valid", valid_cnt[2] - vb, 0);
        checkOutput("rst_no_ferr", err_cnt[2] - eb, 0);
        applyStimulus(2, 8'h81, 1'b1, P_C);
        repeat (10) @(negedge clk);
        checkOutput("81_count", valid_cnt[2] - vb, 1);
        checkOutput("81_data", valid_dat[2][vb], 8'h81);
        checkOutput("81_hold", rx_data_c, 8'h81);

        // Fast clock ratio: P=8, H=4.
        vb = valid_cnt[1];
        eb = err_cnt[1];
        e0 = cycle + 1;
        applyStimulus(1, 8'h55, 1'b1, P_B);
        repeat (10) @(negedge clk);
        checkOutput("55_count", valid_cnt[1] - vb, 1);
        checkOutput("55_data", valid_dat[1][vb], 8'h55);
        checkOutput("55_latency", valid_cyc[1][vb] - e0, LAT_B);
        checkOutput("55_no_ferr", err_cnt[1] - eb, 0);

        checkOutput("valid_ferr_overlap", overlap_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver: 8 data bits, no parity, 1 stop bit (8N1), LSB first, line idle high. It sits between an external RX pin and the byte-oriented logic of the design. It synchronises the pin to the system clock, detects and validates the start bit, and samples each bit at its centre. Each correctly framed byte is presented with a one-cycle valid strobe.

## Interface
Parameters:
- CLK_FREQ_HZ, 12000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line bit rate in bit/s.
- BAUD_PERIOD_CYCLES (derived, localparam): P = CLK_FREQ_HZ / BAUD_RATE, integer division. Default 1250.
- HALF_PERIOD_CYCLES (derived, localparam): H = P / 2. Default 625.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- rx  input  1  asynchronous serial line; idle = 1.
- rx_data  output  8  last correctly received byte; holds until the next good frame.
- rx_data_valid  output  1  one-cycle pulse; rx_data is new in this cycle.
- rx_frame_error  output  1  one-cycle pulse when the stop bit is sampled 0.

## Operation
- Synchroniser: rx passes through 2 flops to give rx_s. Both flops reset to 1. All decisions use rx_s only.
- Counters:
  - cnt: sized to hold P-1.
  - bit_idx: 3 bits.
  - shift: 8-bit shift register, filled LSB first.
- IDLE:
  - rx_s==0 -> START, cnt<=0.
- START:
  - cnt increments each cycle.
  - At cnt==H-1: if rx_s==0 -> DATA with cnt<=0, bit_idx<=0.
  - At cnt==H-1: if rx_s==1 -> IDLE (glitch rejected, no output activity).
- DATA:
  - cnt increments each cycle.
  - At cnt==P-1: shift in rx_s as bit bit_idx, cnt<=0.
  - After bit 7 -> STOP; otherwise bit_idx++.
- STOP, at cnt==P-1:
  - rx_s==1: rx_data<=assembled byte, rx_data_valid<=1 for one cycle, -> IDLE.
  - rx_s==0: rx_frame_error<=1 for one cycle, rx_data unchanged, -> WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1, then -> IDLE.
  - A continuous low (break) therefore produces exactly one frame_error and no further frames.
- Returning to IDLE at the stop-bit centre lets a following start bit (next falling edge) be caught with no idle gap required.
- Reset:
  - Applies on any cycle and aborts a frame in progress.
  - State IDLE, cnt=0, bit_idx=0, shift=0, rx_data=8'h00, rx_data_valid=0, rx_frame_error=0, sync flops=1.
- rx_data_valid and rx_frame_error are registered and never high in the same cycle.

## Timing
- Let E0 be the first rising edge at which the rx pin is sampled 0 (start-bit leading edge).
- IDLE sees rx_s==0 at edge E0+2.
- Start bit is checked at E0+2+H.
- Data bit k (k=0..7) is sampled at E0+2+H+(k+1)·P.
- Stop bit is sampled at E0+2+H+9·P.
- rx_data_valid (or rx_frame_error) is high for exactly the one cycle following that edge.
- Default latency: 2+625+11250 = 11877 cycles from E0.
- Sample point sits mid-bit. Tolerates roughly ±4% baud mismatch over a frame.
- Start glitches shorter than H cycles (after synchronisation) produce nothing.

## Test plan
- Defaults; idle high, then start, bits 1,1,0,1,1,1,1,1 (LSB first), stop 1, each held P=1250 cycles -> rx_data=8'hFB, rx_data_valid high exactly one cycle, 11877 cycles after E0; rx_frame_error stays 0.
- Frames 8'h00 then 8'hFF back-to-back, one stop bit, no idle gap -> two valid pulses with rx_data 8'h00 then 8'hFF, exactly 10·P cycles apart.
- rx low for 300 cycles, then high for 2·P cycles -> no valid pulse, no frame_error; a following 8'hA5 frame is received correctly.
- Frame 8'h3C with stop bit 0, line held low for 3·P, then high -> single rx_frame_error pulse at the stop sample; rx_data keeps its prior value; the next 8'h5A frame is received.
- rst asserted for 1 cycle midway through data bit 4 of a frame -> all outputs 0 the next cycle; the remaining frame bits never cause a spurious valid; a clean 8'h81 frame afterwards is received.
- CLK_FREQ_HZ=1000000, BAUD_RATE=115200 (P=8, H=4); frame 8'h55 -> rx_data=8'h55, valid 2+4+72=78 cycles after E0.
